// File: rtl/line_pkg.sv
// rtl/line_pkg.sv - shared constants, FSM state type and {x,y} packing for the line plotter
package line_pkg;

    localparam int DEF_COORD_W = 4;
    localparam int FB_DIM      = 2 ** DEF_COORD_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN
    } fb_state_t;

    // Same packing the line drawer emits: x in the upper half, y in the lower half.
    function automatic logic [2*DEF_COORD_W-1:0] pack_xy(input logic [DEF_COORD_W-1:0] x,
                                                          input logic [DEF_COORD_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/line_fb_mem.sv
// rtl/line_fb_mem.sv - square bit-per-pixel register framebuffer (LINE_PLOT_XOR_EN: toggle writes)
module line_fb_mem
    import line_pkg::*;
#(
    parameter int W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [W-1:0]       wr_x,
    input  logic [W-1:0]       wr_y,
    output logic               wr_prior,
    input  logic               clr_en,
    input  logic [W-1:0]       clr_row,
    input  logic [W-1:0]       rd_row,
    output logic [(1<<W)-1:0]  rd_data
);

    localparam int DIM = 1 << W;

    logic [DIM-1:0] rows [DIM];

    // Prior bit lets the top keep pix_count exact without a popcount.
    assign wr_prior = rows[wr_y][wr_x];
    assign rd_data  = rows[rd_row];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DIM; r++) begin
                rows[r] <= '0;
            end
        end else begin
            if (clr_en) begin
                rows[clr_row] <= '0;
            end
            if (wr_en) begin
`ifdef LINE_PLOT_XOR_EN
                rows[wr_y][wr_x] <= ~wr_prior;
`else
                rows[wr_y][wr_x] <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/line_plot_fb.sv
// rtl/line_plot_fb.sv - pixel plotter with row-wise clear and scan-out (LINE_PLOT_XOR_EN: XOR plotting)
module line_plot_fb
    import line_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*COORD_W-1:0]     in_xy,
    input  logic                     clear,
    input  logic                     scan_start,
    output logic                     scan_valid,
    input  logic                     scan_ready,
    output logic [COORD_W-1:0]       scan_row,
    output logic [(1<<COORD_W)-1:0]  scan_data,
    output logic                     busy,
    output logic [2*COORD_W:0]       pix_count
);

    localparam int DIM = 1 << COORD_W;

    fb_state_t          state, state_next;
    logic [COORD_W-1:0] row_q;
    logic               last_row;
    logic               wr_en;
    logic               wr_prior;
    logic [DIM-1:0]     rd_data;

    assign last_row   = &row_q;
    assign in_ready   = (state == ST_IDLE);
    assign wr_en      = in_valid && in_ready;
    assign busy       = (state != ST_IDLE);
    assign scan_valid = (state == ST_SCAN);
    assign scan_row   = scan_valid ? row_q : '0;
    assign scan_data  = scan_valid ? rd_data : '0;

    line_fb_mem #(.W(COORD_W)) u_mem (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_x     (in_xy[2*COORD_W-1:COORD_W]),
        .wr_y     (in_xy[COORD_W-1:0]),
        .wr_prior (wr_prior),
        .clr_en   (state == ST_CLEAR),
        .clr_row  (row_q),
        .rd_row   (row_q),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // clear has priority over scan_start; requests outside IDLE are dropped.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (clear) begin
                    state_next = ST_CLEAR;
                end else if (scan_start) begin
                    state_next = ST_SCAN;
                end
            end
            ST_CLEAR: begin
                if (last_row) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_ready && last_row) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // One row counter serves both CLEAR and SCAN; it wraps back to 0 on the last row.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
        end else if ((state == ST_CLEAR) || ((state == ST_SCAN) && scan_ready)) begin
            row_q <= row_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_count <= '0;
        end else if ((state == ST_CLEAR) && last_row) begin
            pix_count <= '0;
        end else if (wr_en) begin
`ifdef LINE_PLOT_XOR_EN
            if (wr_prior) begin
                pix_count <= pix_count - 1'b1;
            end else begin
                pix_count <= pix_count + 1'b1;
            end
`else
            if (!wr_prior) begin
                pix_count <= pix_count + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_line_plot_fb.sv
// tb/tb_line_plot_fb.sv - directed self-checking bench for line_plot_fb
module tb_line_plot_fb;
    import line_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_xy = '0;
    logic        clear = 1'b0;
    logic        scan_start = 1'b0;
    logic        scan_valid;
    logic        scan_ready = 1'b0;
    logic [3:0]  scan_row;
    logic [15:0] scan_data;
    logic        busy;
    logic [8:0]  pix_count;

    int tests = 0;
    int fails = 0;

    logic [15:0] got [16];
    int          hs;
    bit          order_ok, stable_ok, ready_ok, timed_out;

    line_plot_fb #(.COORD_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_xy      (in_xy),
        .clear      (clear),
        .scan_start (scan_start),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .scan_row   (scan_row),
        .scan_data  (scan_data),
        .busy       (busy),
        .pix_count  (pix_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0; scan_start = 1'b0; scan_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic write_px(input logic [7:0] xy);
        in_valid = 1'b1; in_xy = xy;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Starts a scan this cycle and records every handshaked row into got[].
    task automatic run_scan(input bit toggle);
        logic [3:0]  prev_row;
        logic [15:0] prev_data;
        bit          have_prev;
        hs = 0; order_ok = 1; stable_ok = 1; ready_ok = 1; timed_out = 1; have_prev = 0;
        prev_row = '0; prev_data = '0;
        for (int r = 0; r < 16; r++) got[r] = 16'hxxxx;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!scan_valid) begin
                timed_out = 0;
                break;
            end
            scan_ready = toggle ? ((c % 2) == 1) : 1'b1;
            if (in_ready) ready_ok = 0;
            if (have_prev && (scan_row !== prev_row || scan_data !== prev_data)) stable_ok = 0;
            if (scan_ready) begin
                got[scan_row] = scan_data;
                if (scan_row !== 4'(hs)) order_ok = 0;
                hs++;
                have_prev = 0;
            end else begin
                have_prev = 1; prev_row = scan_row; prev_data = scan_data;
            end
            @(posedge clk); #1;
        end
        scan_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        tests++; if (scan_valid !== 1'b0) begin fails++; $display("FAIL reset_scan_valid: got %0b expected 0", scan_valid); end
        tests++; if (scan_row !== 4'd0 || scan_data !== 16'h0) begin fails++; $display("FAIL reset_scan_out: got row %0d data %h expected 0 0000", scan_row, scan_data); end
        tests++; if (pix_count !== 9'd0) begin fails++; $display("FAIL reset_pix_count: got %0d expected 0", pix_count); end
    endtask

    task automatic test_basic_scan();
        logic [15:0] exp_row;
        do_reset();
        write_px(pack_xy(4'd0, 4'd0));
        write_px(pack_xy(4'd5, 4'd10));
        in_valid = 1'b1; in_xy = 8'hFF;
        run_scan(1'b0);
        tests++; if (hs !== 16 || timed_out) begin fails++; $display("FAIL basic_handshakes: got %0d (timeout %0b) expected 16", hs, timed_out); end
        for (int r = 0; r < 16; r++) begin
            exp_row = (r == 0) ? 16'h0001 : (r == 10) ? 16'h0020 : (r == 15) ? 16'h8000 : 16'h0000;
            tests++; if (got[r] !== exp_row) begin fails++; $display("FAIL basic_row%0d: got %h expected %h", r, got[r], exp_row); end
        end
        tests++; if (pix_count !== 9'd3) begin fails++; $display("FAIL basic_pix_count: got %0d expected 3", pix_count); end
        tests++; if (busy !== 1'b0 || scan_valid !== 1'b0) begin fails++; $display("FAIL basic_end_idle: got busy %0b valid %0b expected 0 0", busy, scan_valid); end
    endtask

    task automatic test_dup_write();
        logic [8:0]  exp_cnt;
        logic [15:0] exp_row;
`ifdef LINE_PLOT_XOR_EN
        exp_cnt = 9'd0; exp_row = 16'h0000;
`else
        exp_cnt = 9'd1; exp_row = 16'h0020;
`endif
        do_reset();
        write_px(8'h5A);
        write_px(8'h5A);
        tests++; if (pix_count !== exp_cnt) begin fails++; $display("FAIL dup_pix_count: got %0d expected %0d", pix_count, exp_cnt); end
        run_scan(1'b0);
        tests++; if (got[10] !== exp_row) begin fails++; $display("FAIL dup_row10: got %h expected %h", got[10], exp_row); end
    endtask

    task automatic test_stalled_scan();
        do_reset();
        write_px(8'h5A);
        write_px(8'h3C);
        write_px(8'hA1);
        run_scan(1'b1);
        tests++; if (hs !== 16 || timed_out) begin fails++; $display("FAIL stall_handshakes: got %0d (timeout %0b) expected 16", hs, timed_out); end
        tests++; if (!order_ok) begin fails++; $display("FAIL stall_order: got out-of-order rows expected 0..15"); end
        tests++; if (!stable_ok) begin fails++; $display("FAIL stall_stable: got changing row/data expected stable while stalled"); end
        tests++; if (!ready_ok) begin fails++; $display("FAIL stall_in_ready: got in_ready 1 expected 0 during scan"); end
        tests++; if (got[12] !== 16'h0008 || got[1] !== 16'h0400 || got[10] !== 16'h0020) begin
            fails++; $display("FAIL stall_data: got r1 %h r10 %h r12 %h expected 0400 0020 0008", got[1], got[10], got[12]);
        end
    endtask

    task automatic test_clear();
        int  cnt;
        bit  rdy_bad;
        bit  nz;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1; in_xy = 8'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++; if (pix_count !== 9'd256) begin fails++; $display("FAIL fill_pix_count: got %0d expected 256", pix_count); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        cnt = 0; rdy_bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            cnt++;
            if (in_ready) rdy_bad = 1;
            @(posedge clk); #1;
        end
        tests++; if (cnt !== 16) begin fails++; $display("FAIL clear_busy_cycles: got %0d expected 16", cnt); end
        tests++; if (rdy_bad) begin fails++; $display("FAIL clear_in_ready: got 1 expected 0 during clear"); end
        tests++; if (pix_count !== 9'd0) begin fails++; $display("FAIL clear_pix_count: got %0d expected 0", pix_count); end
        run_scan(1'b0);
        nz = 0;
        for (int r = 0; r < 16; r++) if (got[r] !== 16'h0) nz = 1;
        tests++; if (nz || hs !== 16) begin fails++; $display("FAIL clear_scan_zero: got nonzero %0b handshakes %0d expected 0 16", nz, hs); end
    endtask

    task automatic test_clear_scan_collision();
        int cnt;
        bit saw_valid;
        do_reset();
        in_valid = 1'b1; in_xy = 8'h33; clear = 1'b1; scan_start = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0; scan_start = 1'b0;
        tests++; if (busy !== 1'b1 || scan_valid !== 1'b0) begin fails++; $display("FAIL collide_state: got busy %0b valid %0b expected 1 0", busy, scan_valid); end
        tests++; if (pix_count !== 9'd1) begin fails++; $display("FAIL collide_pixel_written: got %0d expected 1", pix_count); end
        cnt = 0; saw_valid = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            if (scan_valid) saw_valid = 1;
            if (c == 3) scan_start = 1'b1;
            else scan_start = 1'b0;
            cnt++;
            @(posedge clk); #1;
        end
        scan_start = 1'b0;
        tests++; if (cnt !== 16) begin fails++; $display("FAIL collide_clear_cycles: got %0d expected 16", cnt); end
        tests++; if (pix_count !== 9'd0) begin fails++; $display("FAIL collide_pix_count: got %0d expected 0", pix_count); end
        @(posedge clk); #1;
        tests++; if (saw_valid || scan_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL collide_no_scan: got saw_valid %0b valid %0b busy %0b expected 0 0 0", saw_valid, scan_valid, busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit reached;
        do_reset();
        write_px(8'h5A);
        write_px(8'h33);
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        scan_ready = 1'b1;
        reached = 0;
        for (int c = 0; c < 40; c++) begin
            if (scan_valid && scan_row == 4'd7) begin
                reached = 1;
                break;
            end
            @(posedge clk); #1;
        end
        tests++; if (!reached) begin fails++; $display("FAIL rstscan_reach_row7: got timeout expected scan_row 7"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; scan_ready = 1'b0;
        tests++; if (scan_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL rstscan_state: got valid %0b busy %0b in_ready %0b expected 0 0 1", scan_valid, busy, in_ready);
        end
        tests++; if (pix_count !== 9'd0 || scan_row !== 4'd0) begin fails++; $display("FAIL rstscan_counts: got pix %0d row %0d expected 0 0", pix_count, scan_row); end
        run_scan(1'b0);
        tests++; if (got[10] !== 16'h0 || got[3] !== 16'h0 || got[0] !== 16'h0) begin
            fails++; $display("FAIL rstscan_fb_zero: got r0 %h r3 %h r10 %h expected 0000", got[0], got[3], got[10]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_dup_write();
        test_stalled_scan();
        test_clear();
        test_clear_scan_collision();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_plot_fb.md
LINE_PLOT_FB -- requirements
Module: line_plot_fb

Interface
REQ-001 Parameter COORD_W, default 4, bits per coordinate; framebuffer is (2**COORD_W) x (2**COORD_W) pixels.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  pixel coordinate present.
REQ-005 in_ready  output  1  block accepts pixel this cycle.
REQ-006 in_xy  input  2*COORD_W  packed pixel {x, y}, x in upper half, matching the line-drawer output format.
REQ-007 clear  input  1  one-cycle request to erase framebuffer.
REQ-008 scan_start  input  1  one-cycle request to read out framebuffer.
REQ-009 scan_valid  output  1  scan_row/scan_data valid.
REQ-010 scan_ready  input  1  consumer accepts current row.
REQ-011 scan_row  output  COORD_W  row (y) index being presented.
REQ-012 scan_data  output  2**COORD_W  row pixels, bit x = pixel (x, scan_row).
REQ-013 busy  output  1  high in CLEAR or SCAN.
REQ-014 pix_count  output  2*COORD_W+1  number of set pixels in framebuffer.

Function
REQ-015 FSM states IDLE, CLEAR, SCAN; only IDLE accepts pixels.
REQ-016 in_ready SHALL equal (state==IDLE) combinationally; a pixel is written when in_valid && in_ready.
REQ-017 Written pixel SHALL be visible in any readout starting the following cycle.
REQ-018 Writing an already-set pixel SHALL leave pix_count unchanged; setting a clear pixel SHALL increment it.
REQ-019 IDLE->CLEAR on clear; CLEAR erases one row per cycle, rows 0..2**COORD_W-1, then returns to IDLE (16 cycles for COORD_W=4); pix_count SHALL be 0 on return.
REQ-020 IDLE->SCAN on scan_start; scan_valid asserts next cycle with scan_row=0.
REQ-021 In SCAN, scan_row/scan_data SHALL hold stable while scan_valid && !scan_ready; row advances on scan_valid && scan_ready.
REQ-022 Handshake on last row SHALL return to IDLE next cycle with scan_valid=0; framebuffer unchanged by scan.
REQ-023 clear and scan_start asserted together in IDLE: clear wins, scan_start dropped.
REQ-024 clear, scan_start asserted outside IDLE SHALL be ignored (no queuing).
REQ-025 A pixel handshake coinciding with clear/scan_start in IDLE SHALL be written before the transition takes effect.
REQ-026 pix_count width guarantees no overflow (max 256 for COORD_W=4).

Reset
REQ-027 On rst: state IDLE, framebuffer all zero, pix_count=0, scan_valid=0, scan_row=0, scan_data=0, busy=0.
REQ-028 rst mid-CLEAR or mid-SCAN SHALL abort immediately; outputs take reset values the next cycle.

Configuration
REQ-029 Macro LINE_PLOT_XOR_EN defined: pixel write toggles the bit; pix_count increments on 0->1, decrements on 1->0.
REQ-030 Macro undefined: pixel write sets the bit (OR), REQ-018 applies; no toggle logic present.

Structure
REQ-031 Shared package line_pkg holds COORD_W default, FB_DIM=2**COORD_W, the FSM state typedef, and the {x,y} packing helper shared with the line drawer.
REQ-032 Sub-module line_fb_mem: FB_DIM x FB_DIM register array with single-pixel write (set/toggle), whole-row clear and row read port, returning prior bit value for pix_count update.

Verification
REQ-033 Reset, write pixels 0x00, 0x5A, 0xFF, scan with scan_ready=1 -> row 0 data 0x0001, row 10 data 0x0020, row 15 data 0x8000, others 0, pix_count=3.
REQ-034 Write 0x5A twice -> pix_count=1 (OR build) / 0 and pixel clear (LINE_PLOT_XOR_EN build).
REQ-035 Scan with scan_ready toggling every other cycle -> exactly 16 handshakes, rows 0..15 in order, data stable while stalled, in_ready=0 throughout.
REQ-036 Fill 256 pixels then clear -> busy high 16 cycles, in_ready low during clear, pix_count=256 before, 0 after, subsequent scan all zero.
REQ-037 clear and scan_start same cycle with in_valid xy=0x33 -> pixel written, CLEAR entered, no scan; after CLEAR pix_count=0.
REQ-038 rst asserted at scan_row=7 -> next cycle scan_valid=0, state IDLE, pix_count=0, in_ready=1.
